// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for the ALU decode/issue stage. It holds the ALU
//                operation encoding, the RV32I opcode values and the
//                issue-entry record.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation codes consumed by the ALU. Codes 12 and 19-31 are never issued.
    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_SLL   = 5'd2,
        ALU_SLT   = 5'd3,
        ALU_SLTU  = 5'd4,
        ALU_XOR   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_OR    = 5'd8,
        ALU_AND   = 5'd9,
        ALU_LUI   = 5'd10,
        ALU_AUIPC = 5'd11,
        ALU_BEQ   = 5'd13,
        ALU_BNE   = 5'd14,
        ALU_BLT   = 5'd15,
        ALU_BGE   = 5'd16,
        ALU_BLTU  = 5'd17,
        ALU_BGEU  = 5'd18
    } alu_op_e;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

    localparam logic [6:0] c_F7_BASE = 7'h00;
    localparam logic [6:0] c_F7_ALT  = 7'h20;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_e     alu_op;
        logic        is_branch;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } issue_entry_t;

    // Base funct3 mapping shared by OP and OP-IMM. SUB and SRA are selected
    // by funct7 at the call site.
    function automatic alu_op_e f3_to_op(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen
//  Description : Combinational RV32I immediate extraction (I, S, U formats).
//                Only instruction bits 31:7 are needed, because the opcode
//                field never contributes to an immediate.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen (
    input  logic [31:7] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_u
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u = {instr[31:12], 12'b0};

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : RV32I decode-and-issue stage. It decodes an instruction into
//                an ALU op code and operands, then issues it from a registered
//                two-entry (head + skid) buffer with valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [4:0]  out_alu_op,
    output logic        out_is_branch,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_illegal
);

    logic [31:0]  w_imm_i;
    logic [31:0]  w_imm_s;
    logic [31:0]  w_imm_u;
    logic [6:0]   w_opcode;
    logic [2:0]   w_f3;
    logic [6:0]   w_f7;
    logic         w_legal;
    logic         w_we;
    issue_entry_t w_dec;
    logic         w_push;
    logic         w_pop;

    issue_entry_t r_head;
    issue_entry_t r_skid;
    logic [1:0]   r_count;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];

    imm_gen u_imm_gen (
        .instr (in_instr[31:7]),
        .imm_i (w_imm_i),
        .imm_s (w_imm_s),
        .imm_u (w_imm_u)
    );

    // Decode the incoming instruction into an issue entry. Illegal encodings
    // collapse to a zeroed ADD with the illegal flag set.
    always_comb begin
        w_dec        = '0;
        w_dec.alu_op = ALU_ADD;
        w_dec.rd     = in_instr[11:7];
        w_legal      = 1'b1;
        w_we         = 1'b1;
        case (w_opcode)
            c_OPC_OP: begin
                w_dec.a = in_rs1_val;
                w_dec.b = in_rs2_val;
                if (w_f7 == c_F7_BASE) begin
                    w_dec.alu_op = f3_to_op(w_f3);
                end else if (w_f7 == c_F7_ALT && w_f3 == 3'd0) begin
                    w_dec.alu_op = ALU_SUB;
                end else if (w_f7 == c_F7_ALT && w_f3 == 3'd5) begin
                    w_dec.alu_op = ALU_SRA;
                end else begin
                    w_legal = 1'b0;
                end
            end
            c_OPC_OP_IMM: begin
                w_dec.a      = in_rs1_val;
                w_dec.b      = w_imm_i;
                w_dec.alu_op = f3_to_op(w_f3);
                if (w_f3 == 3'd1) begin
                    w_legal = (w_f7 == c_F7_BASE);
                end else if (w_f3 == 3'd5) begin
                    if (w_f7 == c_F7_ALT) begin
                        // Pass only the shift amount so the SRAI marker bit
                        // does not reach the ALU.
                        w_dec.alu_op = ALU_SRA;
                        w_dec.b      = {27'b0, in_instr[24:20]};
                    end else if (w_f7 != c_F7_BASE) begin
                        w_legal = 1'b0;
                    end
                end
            end
            c_OPC_LUI: begin
                w_dec.a      = w_imm_u;
                w_dec.alu_op = ALU_LUI;
            end
            c_OPC_AUIPC: begin
                w_dec.a      = in_pc;
                w_dec.b      = w_imm_u;
                w_dec.alu_op = ALU_AUIPC;
            end
            c_OPC_BRANCH: begin
                w_dec.a         = in_rs1_val;
                w_dec.b         = in_rs2_val;
                w_dec.is_branch = 1'b1;
                w_we            = 1'b0;
                case (w_f3)
                    3'd0:    w_dec.alu_op = ALU_BEQ;
                    3'd1:    w_dec.alu_op = ALU_BNE;
                    3'd4:    w_dec.alu_op = ALU_BLT;
                    3'd5:    w_dec.alu_op = ALU_BGE;
                    3'd6:    w_dec.alu_op = ALU_BLTU;
                    3'd7:    w_dec.alu_op = ALU_BGEU;
                    default: w_legal = 1'b0;
                endcase
            end
            c_OPC_LOAD: begin
                w_dec.a = in_rs1_val;
                w_dec.b = w_imm_i;
            end
            c_OPC_STORE: begin
                w_dec.a = in_rs1_val;
                w_dec.b = w_imm_s;
                w_we    = 1'b0;
            end
            c_OPC_JAL, c_OPC_JALR: begin
                w_dec.a = in_pc;
                w_dec.b = 32'd4;
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_dec.a         = '0;
            w_dec.b         = '0;
            w_dec.alu_op    = ALU_ADD;
            w_dec.is_branch = 1'b0;
        end
        w_dec.illegal = !w_legal;
        w_dec.rd_we   = w_we && w_legal && (in_instr[11:7] != 5'd0);
    end

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Head/skid buffer. The head always drives the outputs, and the skid only
    // holds the second entry while the head is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head  <= w_dec;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= w_dec;
                    end else if (w_push) begin
                        r_skid  <= w_dec;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head  <= r_skid;
                        r_count <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign out_a         = r_head.a;
    assign out_b         = r_head.b;
    assign out_alu_op    = r_head.alu_op;
    assign out_is_branch = r_head.is_branch;
    assign out_rd        = r_head.rd;
    assign out_rd_we     = r_head.rd_we;
    assign out_illegal   = r_head.illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue
//  Description : Self-checking bench for alu_issue. Directed cases come first,
//                followed by randomized traffic checked against a queue-based
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1_val, in_rs2_val, out_a, out_b;
    logic [4:0]  out_alu_op, out_rd;
    logic        out_is_branch, out_rd_we, out_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          op;
        bit          br;
        logic [4:0]  rd;
        bit          we;
        bit          ill;
    } exp_t;

    exp_t q[$];
    bit   just_rst = 1'b0;

    alu_issue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_rs1_val    (in_rs1_val),
        .in_rs2_val    (in_rs2_val),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_a         (out_a),
        .out_b         (out_b),
        .out_alu_op    (out_alu_op),
        .out_is_branch (out_is_branch),
        .out_rd        (out_rd),
        .out_rd_we     (out_rd_we),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode, written directly from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        int          lut[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic [2:0]  f3   = ins[14:12];
        logic [6:0]  f7   = ins[31:25];
        logic [31:0] immi = 32'($signed(ins) >>> 20);
        logic [31:0] ims  = 32'($signed({ins[31:25], ins[11:7], 20'b0}) >>> 20);
        logic [31:0] immu = ins & 32'hFFFFF000;
        bit          ok   = 1'b1;
        bit          wr   = 1'b1;
        e = '{a: 0, b: 0, op: 0, br: 0, rd: ins[11:7], we: 0, ill: 0};
        case (ins[6:0])
            7'h33: begin
                e.a = r1; e.b = r2;
                if (f7 == 0) e.op = lut[f3];
                else if (f7 == 7'h20 && f3 == 0) e.op = 1;
                else if (f7 == 7'h20 && f3 == 5) e.op = 7;
                else ok = 0;
            end
            7'h13: begin
                e.a = r1; e.b = immi; e.op = lut[f3];
                if (f3 == 1 && f7 != 0) ok = 0;
                if (f3 == 5) begin
                    if (f7 == 7'h20) begin e.op = 7; e.b = {27'b0, ins[24:20]}; end
                    else if (f7 != 0) ok = 0;
                end
            end
            7'h37: begin e.a = immu; e.op = 10; end
            7'h17: begin e.a = pc; e.b = immu; e.op = 11; end
            7'h63: begin
                e.a = r1; e.b = r2; e.br = 1; wr = 0;
                case (f3)
                    0: e.op = 13;  1: e.op = 14;  4: e.op = 15;
                    5: e.op = 16;  6: e.op = 17;  7: e.op = 18;
                    default: ok = 0;
                endcase
            end
            7'h03: begin e.a = r1; e.b = immi; end
            7'h23: begin e.a = r1; e.b = ims; wr = 0; end
            7'h6F, 7'h67: begin e.a = pc; e.b = 4; end
            default: ok = 0;
        endcase
        if (!ok) begin e.a = 0; e.b = 0; e.op = 0; e.br = 0; end
        e.ill = !ok;
        e.we  = ok && wr && (ins[11:7] != 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom;
        logic [6:0]  opcs[10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h63,
                                  7'h03, 7'h23, 7'h6F, 7'h67, 7'h73};
        ins[6:0] = opcs[$urandom_range(0, 9)];
        if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
            ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return ins;
    endfunction

    // One clock: update the model at the active edge, return at the falling edge.
    task automatic tick();
        int sz;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            just_rst = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            sz = q.size();
            if (out_ready && sz > 0) void'(q.pop_front());
            if (in_valid && sz < 2) begin
                q.push_back(ref_decode(in_instr, in_pc, in_rs1_val, in_rs2_val));
                just_rst = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_model();
        exp_t e;
        chk("valid", 32'(out_valid), 32'(q.size() != 0));
        chk("ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            e = q[0];
            chk("a", out_a, e.a);
            chk("b", out_b, e.b);
            chk("op", 32'(out_alu_op), 32'(e.op));
            chk("br", 32'(out_is_branch), 32'(e.br));
            chk("rd", 32'(out_rd), 32'(e.rd));
            chk("we", 32'(out_rd_we), 32'(e.we));
            chk("ill", 32'(out_illegal), 32'(e.ill));
        end else if (just_rst) begin
            chk("rst_a", out_a, 32'd0);
            chk("rst_op", 32'(out_alu_op), 32'd0);
            chk("rst_flags", {29'd0, out_rd_we, out_is_branch, out_illegal}, 32'd0);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_valid = v; in_instr = ins; in_rs1_val = r1; in_rs2_val = r2;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; in_pc = 32'h1000;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_ab", out_a | out_b, 32'd0);
        chk("rst_fields", {20'd0, out_alu_op, out_rd, out_rd_we, out_is_branch}, 32'd0);
        chk("rst_ill", 32'(out_illegal), 32'd0);
        rst_n = 1'b1;

        drive(1'b1, 32'h40B50533, 32'd7, 32'd3);
        tick();
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_op", 32'(out_alu_op), 32'd1);
        chk("sub_ab", {out_a[15:0], out_b[15:0]}, {16'd7, 16'd3});
        chk("sub_rd", {26'd0, out_rd, out_rd_we}, {26'd0, 5'd10, 1'b1});

        drive(1'b1, 32'h40435293, 32'h80000000, 32'd0);
        tick();
        chk("srai_op", 32'(out_alu_op), 32'd7);
        chk("srai_b", out_b, 32'd4);
        chk("srai_a", out_a, 32'h80000000);
        drive(1'b1, 32'h123450B7, 32'd0, 32'd0);
        tick();
        chk("lui_op", 32'(out_alu_op), 32'd10);
        chk("lui_a", out_a, 32'h12345000);
        chk("lui_b", out_b, 32'd0);

        drive(1'b1, 32'h0020D063, 32'hFFFFFFFF, 32'd1);
        tick();
        chk("bge_op", 32'(out_alu_op), 32'd16);
        chk("bge_br_we", {30'd0, out_is_branch, out_rd_we}, 32'd2);
        chk("bge_a", out_a, 32'hFFFFFFFF);
        drive(1'b1, 32'h0020A063, 32'd5, 32'd6);
        tick();
        chk("bill_ill", 32'(out_illegal), 32'd1);
        chk("bill_op", 32'(out_alu_op), 32'd0);
        chk("bill_ab", out_a | out_b, 32'd0);
        chk("bill_br_we", {30'd0, out_is_branch, out_rd_we}, 32'd0);

        // Backpressure: three back-to-back pushes with the ALU stalled.
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd10, 32'd1);
        tick();
        chk("bp1_ready", 32'(in_ready), 32'd1);
        chk("bp1_a", out_a, 32'd10);
        drive(1'b1, 32'h002081B3, 32'd30, 32'd1);
        tick();
        chk("bp2_ready", 32'(in_ready), 32'd0);
        chk("bp2_a", out_a, 32'd10);
        drive(1'b1, 32'h002081B3, 32'd50, 32'd1);
        tick();
        chk("bp3_ready", 32'(in_ready), 32'd0);
        chk("bp3_a_hold", out_a, 32'd10);
        out_ready = 1'b1;
        tick();
        chk("drain1_a", out_a, 32'd30);
        chk("drain1_ready", 32'(in_ready), 32'd1);
        tick();
        chk("drain2_a", out_a, 32'd50);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Flush with a full buffer and a same-cycle push.
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd1, 32'd1);
        tick(); tick();
        chk("fl_full", 32'(in_ready), 32'd0);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        tick();
        chk("fl_still_empty", 32'(out_valid), 32'd0);

        // Randomized traffic against the queue model.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            in_pc     = $urandom & 32'hFFFFFFFC;
            drive(($urandom_range(0, 9) < 7), rand_instr(), $urandom, $urandom);
            tick();
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
